// File: rtl/stream_golden_checker_pkg.sv
// rtl/stream_golden_checker_pkg.sv - shared types and constants for the golden-vector stream checkers
//
// Provides the checker FSM state type, the re-hunt threshold used when the
// sync-hunt option is enabled, and per-stage compare masks.
package stream_golden_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } checker_state_t;

  // Consecutive mismatched beats in CHECK that declare loss of alignment.
  localparam int SYNC_LOSS_THR = 4;

  // Modulator {I,Q} output: only the I and Q sign bits are deterministic.
  localparam logic [31:0] MOD_SIGN_MASK = 32'h8000_8000;
  // Bit-serial stages (PRBS, FEC, interleaver) compare their single bit.
  localparam logic [0:0]  BIT_STREAM_MASK = 1'b1;

endpackage

// File: rtl/stream_golden_checker_golden_rom_mux.sv
// rtl/stream_golden_checker_golden_rom_mux.sv - combinational beat selector over a packed golden frame
//
// Ports:
//   idx  - beat index within the frame
//   beat - golden beat at idx; beat 0 sits in the most significant DATA_W bits
// Out-of-range indices return zero.
module golden_rom_mux #(
  parameter int                            DATA_W    = 1,
  parameter int                            FRAME_LEN = 96,
  parameter int                            IDX_W     = $clog2(FRAME_LEN),
  parameter logic [FRAME_LEN*DATA_W-1:0]   GOLDEN    = '0
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] beat
);

  logic [FRAME_LEN*DATA_W-1:0] rom;

  assign rom = GOLDEN;

  always_comb begin
    beat = '0;
    if (int'(idx) < FRAME_LEN) begin
      beat = rom[(FRAME_LEN - 1 - int'(idx)) * DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/stream_golden_checker.sv
// rtl/stream_golden_checker.sv - golden-vector checker for a valid-qualified PHY stage stream
//
// Compares each valid beat against a frame-length golden ROM under a per-bit
// mask, counts mismatches (saturating), captures the first mismatch, counts
// frames and reports busy/done/pass for board-level self-test.
//
// Ports:
//   clk, reset      - single clock, synchronous active-high reset
//   start           - one-cycle pulse: clear statistics and arm
//   valid_in        - beat qualifier
//   data_in         - beat data
//   busy, done      - FSM in ARMED/CHECK, FSM in DONE
//   pass            - at least one beat compared and no mismatch seen
//   err_count       - saturating mismatch count
//   first_err_*     - capture of the first mismatch (valid, beat index, frame)
//   frame_count     - completed frames (wraps)
//   sync_lost       - sticky re-hunt flag (only with STREAM_GOLDEN_CHECKER_SYNC_HUNT_EN)
//
// Option macro STREAM_GOLDEN_CHECKER_SYNC_HUNT_EN: ARMED hunts for a beat
// matching golden beat 0, and SYNC_LOSS_THR consecutive mismatches in CHECK
// return to the hunt.
module stream_golden_checker
  import stream_golden_checker_pkg::*;
#(
  parameter int                            DATA_W     = 1,
  parameter int                            FRAME_LEN  = 96,
  parameter logic [FRAME_LEN*DATA_W-1:0]   GOLDEN     = '0,
  parameter logic [DATA_W-1:0]             CMP_MASK   = '1,
  parameter int                            NUM_FRAMES = 0,
  parameter int                            ERR_W      = 8,
  parameter int                            IDX_W      = $clog2(FRAME_LEN),
  parameter int                            FRM_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [FRM_W-1:0]  first_err_frame,
`ifdef STREAM_GOLDEN_CHECKER_SYNC_HUNT_EN
  output logic              sync_lost,
`endif
  output logic [FRM_W-1:0]  frame_count
);

  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(FRAME_LEN - 1);
  localparam logic [FRM_W-1:0] NUM_FRAMES_V = FRM_W'(NUM_FRAMES);
  localparam logic [ERR_W-1:0] ERR_MAX      = '1;

  checker_state_t    state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] golden_beat;
  logic              mismatch;
  logic              take;
  logic              last_beat;
  logic              reach_done;
  logic              rehunt;

  golden_rom_mux #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .IDX_W     (IDX_W),
    .GOLDEN    (GOLDEN)
  ) u_golden_rom_mux (
    .idx  (idx),
    .beat (golden_beat)
  );

  assign mismatch   = |((data_in ^ golden_beat) & CMP_MASK);
  assign last_beat  = (idx == LAST_IDX);
  // Frame-limited runs stop on the boundary that completes the last frame.
  assign reach_done = (NUM_FRAMES != 0) && last_beat &&
                      ((frame_count + FRM_W'(1)) == NUM_FRAMES_V);

`ifdef STREAM_GOLDEN_CHECKER_SYNC_HUNT_EN
  localparam logic [2:0] MISS_LAST = 3'(SYNC_LOSS_THR - 1);
  logic [2:0] miss_run;

  assign rehunt = (state == CHECK) && mismatch && (miss_run == MISS_LAST);
`else
  assign rehunt = 1'b0;
`endif

  assign busy = (state == ARMED) || (state == CHECK);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // take marks a beat that is compared and advances the index.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    if (start) begin
      state_nxt = ARMED;
    end else begin
      case (state)
        ARMED: begin
          if (valid_in) begin
`ifdef STREAM_GOLDEN_CHECKER_SYNC_HUNT_EN
            // Hunting: only a beat equal to golden beat 0 locks the frame.
            if (!mismatch) begin
              take      = 1'b1;
              state_nxt = CHECK;
            end
`else
            take      = 1'b1;
            state_nxt = CHECK;
`endif
          end
        end
        CHECK: begin
          if (valid_in) begin
            take = 1'b1;
          end
        end
        default: begin
        end
      endcase
      if (take) begin
        if (rehunt) begin
          state_nxt = ARMED;
        end else if (reach_done) begin
          state_nxt = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      idx             <= '0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_frame <= '0;
      frame_count     <= '0;
`ifdef STREAM_GOLDEN_CHECKER_SYNC_HUNT_EN
      sync_lost       <= 1'b0;
      miss_run        <= '0;
`endif
    end else if (take) begin
      if (mismatch) begin
        if (err_count != ERR_MAX) begin
          err_count <= err_count + ERR_W'(1);
        end
        pass <= 1'b0;
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_idx   <= idx;
          // Frame number before any boundary increment in this same cycle.
          first_err_frame <= frame_count;
        end
      end else if (!first_err_valid) begin
        pass <= 1'b1;
      end

      if (rehunt) begin
        // The partial frame is abandoned, so frame_count is not advanced.
        idx <= '0;
      end else if (last_beat) begin
        idx         <= '0;
        frame_count <= frame_count + FRM_W'(1);
      end else begin
        idx <= idx + IDX_W'(1);
      end

`ifdef STREAM_GOLDEN_CHECKER_SYNC_HUNT_EN
      if (rehunt) begin
        sync_lost <= 1'b1;
      end
      if (rehunt || !mismatch) begin
        miss_run <= '0;
      end else begin
        miss_run <= miss_run + 3'd1;
      end
`endif
    end
  end

endmodule

// File: doc/stream_golden_checker.md
Name: stream_golden_checker

Overview:
- Parametrised on-chip golden-vector checker for any WiMAX PHY stage output (PRBS, FEC, interleaver, modulator).
- Compares a valid-qualified stream against a frame-length golden ROM held in a parameter, under a per-bit compare mask.
- Counts errors with saturation, captures the first mismatch, tracks frames, and drives pass/done flags for board-level self-test.
- Replaces per-stage hand-written check loops with one block, instanced once per stage.

Parameters:
- DATA_W, 1: beat width in bits (1 for bit streams; 32 for {I,Q} modulator output).
- FRAME_LEN, 96: beats per golden frame (96 for randomizer, 192 for FEC/interleaver).
- GOLDEN, '0: packed golden ROM, [FRAME_LEN*DATA_W-1:0]; beat k = GOLDEN[(FRAME_LEN-1-k)*DATA_W +: DATA_W] (MSB-first).
- CMP_MASK, all ones: per-bit compare mask; only bits set to 1 are compared (e.g. sign bits 31 and 15 for the modulator).
- NUM_FRAMES, 0: frames to check before DONE; 0 = continuous.
- ERR_W, 8: error counter width.
- IDX_W, $clog2(FRAME_LEN): beat index width.
- FRM_W, 8: frame counter width.

Ports:
- clk, input, 1: single clock; all logic on its posedge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle pulse; arms the checker and clears all statistics.
- valid_in, input, 1: beat qualifier from the stage under test.
- data_in, input, DATA_W: beat data.
- busy, output, 1: high in ARMED or CHECK.
- done, output, 1: high in DONE.
- pass, output, 1: at least one beat compared AND err_count==0.
- err_count, output, ERR_W: saturating count of mismatched beats.
- first_err_valid, output, 1: a mismatch has been captured.
- first_err_idx, output, IDX_W: beat index of the first mismatch.
- first_err_frame, output, FRM_W: frame number of the first mismatch.
- frame_count, output, FRM_W: completed frames (wraps).

Behaviour:
- Reset (synchronous, dominates start):
  - State goes to IDLE.
  - Every output register clears to 0; the internal beat index clears to 0.
- FSM states: IDLE, ARMED, CHECK, DONE.
  - IDLE -> ARMED on start.
  - ARMED -> CHECK on the first valid_in beat; that beat is compared as index 0.
  - CHECK -> DONE when frame_count reaches NUM_FRAMES at a frame boundary (only if NUM_FRAMES != 0).
  - DONE -> ARMED on start.
  - start in any state clears the stats and goes to ARMED.
  - start together with valid_in: start wins and the beat is ignored.
- Compare rule:
  - A beat mismatches when ((data_in ^ golden[idx]) & CMP_MASK) != 0.
  - Compares happen only in ARMED or CHECK with valid_in=1.
  - Beats with valid_in=0 do not advance idx.
- Latency: each output reflects a beat one cycle after the cycle it is presented (registered outputs).
- Index wrap:
  - Normal step: idx increments per compared beat.
  - At idx==FRAME_LEN-1: idx returns to 0 and frame_count increments in the same cycle. A mismatch on that last beat still records frame_count before the increment.
- Error counter: err_count saturates at 2^ERR_W-1 and does not wrap.
- First-error capture:
  - first_err_* load only on the first mismatch after start.
  - They hold until the next start or reset.
- pass: registered flag; set after the first compared beat if no error has occurred; cleared permanently by any mismatch until the next start.
- DONE: ignores valid_in; all stats hold.
- Reset mid-frame: abandons the check. No partial frame is counted.

Optional Feature:
- Macro: STREAM_GOLDEN_CHECKER_SYNC_HUNT_EN.
- When defined:
  - ARMED becomes a hunt state that advances to CHECK only on a beat matching golden[0] under the mask. Non-matching beats are discarded and not counted.
  - In CHECK, 4 consecutive mismatched beats return the FSM to ARMED (re-hunt) with idx=0. err_count keeps accumulating.
  - Adds output sync_lost (1 bit), a sticky flag set on the first re-hunt and cleared by start or reset.
- When undefined: first valid beat is index 0; no re-hunt logic and no sync_lost port.

Decomposition:
- Package_wimax gains:
  - checker_state_t enum (IDLE, ARMED, CHECK, DONE).
  - Constant SYNC_LOSS_THR = 4.
  - Per-stage mask constants (e.g. MOD_SIGN_MASK = 32'h8000_8000).
- Golden vectors remain in Package_wimax and are passed via GOLDEN.
- One natural sub-module: golden_rom_mux, which maps (GOLDEN, idx) to golden beat; purely combinational and reusable by other stage checkers.

Test Plan:
- DATA_W=1, FRAME_LEN=8, GOLDEN=8'hA5, NUM_FRAMES=2; start, then 16 correct beats -> done=1, pass=1, err_count=0, frame_count=2.
- Same config, beat 3 of frame 1 inverted -> err_count=1, pass=0, first_err_idx=3, first_err_frame=1, done=1.
- ERR_W=2, every beat wrong over 8 beats -> err_count saturates at 3; first_err_idx=0.
- DATA_W=32, CMP_MASK=32'h8000_8000, data differs only in bits 14:0 -> err_count=0, pass=1.
- Reset asserted mid-frame at idx=5, then start plus correct frame -> frame_count=1, err_count=0, no stale first_err_valid.
- SYNC_HUNT_EN, 3 garbage beats then aligned stream -> CHECK entered on the golden[0] beat, err_count=0. Later 4 bad beats -> sync_lost=1, re-hunt, err_count=4.
